keypad_scan_decoder: RTL and testbench

KEYPAD_SCAN_DECODER -- requirements
Module: keypad_scan_decoder

---
 rtl/keypad_scan_decoder_pkg.sv | 37 +++
 rtl/keypad_scan_decoder_if.sv | 32 +++
 rtl/keypad_scan_decoder_sync_2ff.sv | 34 +++
 rtl/keypad_scan_decoder.sv | 177 +++++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_decoder_pkg
// Description : Shared FSM encoding, key-code constants and 4x4 key map for
//               the keypad scan decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Indexed by {row_index, col_index}; element 0 is row 0 / column 0.
    localparam logic [15:0][3:0] c_key_map = {
        4'hD, KEY_HASH, 4'h0, KEY_STAR,   // row 3
        4'hC, 4'h9,     4'h8, 4'h7,       // row 2
        4'hB, 4'h6,     4'h5, 4'h4,       // row 1
        4'hA, 4'h3,     4'h2, 4'h1        // row 0
    };

    // Lowest-index active-low row bit; only meaningful when some bit is low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
        if (!r[0])      return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        else            return 2'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_decoder_if
// Description : Decoded-key handshake between the scanner and its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scan_decoder_if;

    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    modport master (
        output key_valid,
        output key_code,
        output key_held,
        output overrun,
        input  key_ack
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_held,
        input  overrun,
        output key_ack
    );

endinterface
`default_nettype wire

// File: rtl/keypad_scan_decoder_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for asynchronous level inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops; reset value matches the idle level of the input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_decoder
// Description : 4x4 matrix keypad column scanner with press/release debounce,
//               key decoding and a valid/ack handshake with overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_decoder
    import keypad_scan_decoder_pkg::*;
#(
    parameter int SCAN_DIV = 50_000,
    parameter int DEBOUNCE = 20
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       en,
    input  wire logic [3:0] row,
    output logic      [3:0] col,
    keypad_scan_decoder_if.master kif
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] c_dwell_last = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  c_db_last    = DB_W'(DEBOUNCE - 1);

    state_t            r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_dwell;
    logic [1:0]        r_col_idx, w_col_idx_nxt;
    logic [DB_W-1:0]   r_db_cnt, w_db_cnt_nxt;
    logic [3:0]        r_row_lat, w_row_lat_nxt;
    logic [3:0]        w_row_s;
    logic              w_dwell_end;
    logic              w_row_idle;
    logic              w_accept;
    logic              w_release;
    logic              r_accept_d;
    logic              r_key_valid;
    logic [3:0]        r_key_code;
    logic              r_key_held;
    logic              r_overrun;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (w_row_s)
    );

    assign w_dwell_end = en && (r_dwell == c_dwell_last);
    assign w_row_idle  = &w_row_s;
    assign col         = en ? ~(4'b0001 << r_col_idx) : 4'hF;

    // Dwell timer; disabling scan rewinds it so re-enable starts a full dwell.
    always_ff @(posedge clk) begin
        if (!rst || !en || w_dwell_end) r_dwell <= '0;
        else                            r_dwell <= r_dwell + DIV_W'(1);
    end

    // FSM, column index, debounce count and latched row pattern registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_SCAN;
            r_col_idx <= 2'd0;
            r_db_cnt  <= '0;
            r_row_lat <= 4'hF;
        end else begin
            r_state   <= w_state_nxt;
            r_col_idx <= w_col_idx_nxt;
            r_db_cnt  <= w_db_cnt_nxt;
            r_row_lat <= w_row_lat_nxt;
        end
    end

    // Next-state logic evaluated only on the single row sample per dwell.
    // Release counting includes the all-high sample that leaves PRESSED.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_idx_nxt = r_col_idx;
        w_db_cnt_nxt  = r_db_cnt;
        w_row_lat_nxt = r_row_lat;
        w_accept      = 1'b0;
        w_release     = 1'b0;
        if (w_dwell_end) begin
            case (r_state)
                ST_SCAN: begin
                    if (!w_row_idle) begin
                        w_row_lat_nxt = w_row_s;
                        w_db_cnt_nxt  = '0;
                        w_state_nxt   = ST_PRESS_DB;
                    end else begin
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end
                end
                ST_PRESS_DB: begin
                    if (w_row_s == r_row_lat) begin
                        if (r_db_cnt == c_db_last) begin
                            w_db_cnt_nxt = '0;
                            w_state_nxt  = ST_PRESSED;
                            w_accept     = 1'b1;
                        end else begin
                            w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                        end
                    end else begin
                        w_db_cnt_nxt  = '0;
                        w_col_idx_nxt = r_col_idx + 2'd1;
                        w_state_nxt   = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (w_row_idle) begin
                        w_db_cnt_nxt = DB_W'(1);
                        w_state_nxt  = ST_RELEASE_DB;
                    end
                end
                ST_RELEASE_DB: begin
                    if (w_row_idle) begin
                        if (r_db_cnt >= c_db_last) begin
                            w_db_cnt_nxt  = '0;
                            w_col_idx_nxt = r_col_idx + 2'd1;
                            w_state_nxt   = ST_SCAN;
                            w_release     = 1'b1;
                        end else begin
                            w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                        end
                    end else begin
                        w_db_cnt_nxt = '0;
                        w_state_nxt  = ST_PRESSED;
                    end
                end
                default: w_state_nxt = ST_SCAN;
            endcase
        end
    end

    // Key code and held flag update at PRESSED entry; valid follows a cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_key_code <= 4'h0;
            r_key_held <= 1'b0;
            r_accept_d <= 1'b0;
        end else begin
            r_accept_d <= w_accept;
            if (w_accept) begin
                r_key_code <= c_key_map[{lowest_low_row(r_row_lat), r_col_idx}];
                r_key_held <= 1'b1;
            end else if (w_release) begin
                r_key_held <= 1'b0;
            end
        end
    end

    // Valid/ack handshake; an ack coinciding with a new key does not overrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_accept_d) begin
                r_key_valid <= 1'b1;
                if (r_key_valid && !kif.key_ack) r_overrun <= 1'b1;
            end else if (kif.key_ack) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign kif.key_valid = r_key_valid;
    assign kif.key_code  = r_key_code;
    assign kif.key_held  = r_key_held;
    assign kif.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_decoder
// Description : Scoreboard bench for keypad_scan_decoder with a keypad matrix
//               emulation and a sample-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_decoder;

    localparam int DIV = 4;
    localparam int DB  = 3;
    localparam int M_SCAN = 0, M_CONFIRM = 1, M_HELD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b1;
    logic        ack = 1'b0;
    logic [15:0] mask = 16'h0;     // bit r*4+c set = key (r,c) physically pressed
    logic [3:0]  row;
    logic [3:0]  col;

    int checks = 0;
    int fails  = 0;

    // Key legend "123A / 456B / 789C / *0#D" as hex codes, index r*4+c.
    int key_tbl [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_scan_decoder_if kif();
    assign kif.key_ack = ack;

    keypad_scan_decoder #(.SCAN_DIV(DIV), .DEBOUNCE(DB)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .row (row),
        .col (col),
        .kif (kif.master)
    );

    always #5 clk = ~clk;

    // Passive matrix: a row reads low when a pressed key joins it to a low column.
    function automatic logic [3:0] keypad(input logic [15:0] m, input logic [3:0] c);
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (m[ri*4+ci] && !c[ci]) r[ri] = 1'b0;
        return r;
    endfunction

    assign row = keypad(mask, col);

    // ---------------- reference model (one step per clock) ----------------
    int         m_mode = M_SCAN, m_col = 0, m_dwell = 0, m_run = 0;
    logic [3:0] m_lat = 4'hF, s1 = 4'hF, s2 = 4'hF, m_code = 4'h0;
    bit         m_valid = 0, m_ovr = 0, m_pend = 0, m_held = 0;
    logic [3:0] exp_q [$];

    function automatic logic [3:0] m_col_out();
        return en ? ~(4'b0001 << m_col) : 4'hF;
    endfunction

    always @(posedge clk) begin
        logic [3:0] rnow, smp;
        bit         dend;
        int         lr;
        rnow = keypad(mask, m_col_out());
        if (!rst) begin
            m_mode = M_SCAN; m_col = 0; m_dwell = 0; m_run = 0; m_lat = 4'hF;
            s1 = 4'hF; s2 = 4'hF; m_code = 4'h0;
            m_valid = 0; m_ovr = 0; m_pend = 0; m_held = 0;
        end else begin
            smp = s2; s2 = s1; s1 = rnow;
            dend = en && (m_dwell == DIV - 1);
            m_dwell = (!en || dend) ? 0 : m_dwell + 1;
            if (m_pend) begin
                if (m_valid && !ack) m_ovr = 1;
                m_valid = 1;
            end else if (ack) begin
                m_valid = 0;
            end
            m_pend = 0;
            if (dend) begin
                case (m_mode)
                    M_SCAN: begin
                        if (smp != 4'hF) begin m_lat = smp; m_run = 0; m_mode = M_CONFIRM; end
                        else m_col = (m_col + 1) % 4;
                    end
                    M_CONFIRM: begin
                        if (smp == m_lat) begin
                            m_run++;
                            if (m_run == DB) begin
                                lr = 0;
                                while (m_lat[lr]) lr++;
                                m_code = 4'(key_tbl[lr*4 + m_col]);
                                exp_q.push_back(m_code);
                                m_held = 1; m_pend = 1; m_run = 0; m_mode = M_HELD;
                            end
                        end else begin
                            m_mode = M_SCAN; m_col = (m_col + 1) % 4;
                        end
                    end
                    default: begin
                        // Count the consecutive all-high samples since acceptance.
                        m_run = (smp == 4'hF) ? m_run + 1 : 0;
                        if (m_run == DB) begin
                            m_held = 0; m_run = 0; m_mode = M_SCAN; m_col = (m_col + 1) % 4;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit prev_held = 0, chk_valid = 0;

    always begin
        logic [3:0] e;
        @(posedge clk);
        #1;
        checks++;
        if ({col, kif.key_held, kif.key_valid, kif.overrun, kif.key_code} !==
            {m_col_out(), m_held, m_valid, m_ovr, m_code}) begin
            fails++;
            $display("FAIL status t=%0t: col=%b held=%b valid=%b ovr=%b code=%h, expected col=%b held=%b valid=%b ovr=%b code=%h",
                     $time, col, kif.key_held, kif.key_valid, kif.overrun, kif.key_code,
                     m_col_out(), m_held, m_valid, m_ovr, m_code);
        end
        if (chk_valid) begin
            checks++;
            if (kif.key_valid !== 1'b1) begin
                fails++;
                $display("FAIL valid_rise t=%0t: key_valid=%b one cycle after key_held rose, expected 1", $time, kif.key_valid);
            end
        end
        chk_valid = 0;
        if (rst && kif.key_held === 1'b1 && !prev_held) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL key_pop t=%0t: unexpected key %h, no key expected", $time, kif.key_code);
            end else begin
                e = exp_q.pop_front();
                if (kif.key_code !== e) begin
                    fails++;
                    $display("FAIL key_pop t=%0t: key_code=%h expected %h", $time, kif.key_code, e);
                end
            end
            chk_valid = 1;
        end
        prev_held = rst && (kif.key_held === 1'b1);
    end

    // ---------------- acknowledge driver ----------------
    int ack_req = 0, ack_done = 0;
    bit ack_rand = 0;

    always begin
        @(negedge clk);
        if (ack_req != ack_done) begin ack = 1'b1; ack_done = ack_req; end
        else if (ack_rand)       ack = ($urandom_range(0, 3) == 0);
        else                     ack = 1'b0;
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_mode(input int mode, input bit need_valid, input int budget, input string name);
        int n = 0;
        while (!(m_mode == mode && (!need_valid || m_valid)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++; fails++;
            $display("FAIL %s: timed out after %0d cycles waiting for model mode %0d", name, budget, mode);
        end
    endtask

    task automatic press(input logic [15:0] m, input int hold, input int gap);
        mask = m;
        repeat (hold) @(negedge clk);
        mask = 16'h0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_ack();
        ack_req++;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {col, kif.key_valid, kif.key_code, kif.key_held, kif.overrun}, {4'hE, 1'b0, 4'h0, 1'b0, 1'b0});
        rst = 1'b1;

        // Key '5' (row 1, column 1) held for many dwells, then released.
        press(16'h1 << 5, 100, 60);
        check("key5_code", {kif.key_code, kif.key_valid, kif.key_held}, {4'h5, 1'b1, 1'b0});
        do_ack();
        check("key5_ack", kif.key_valid, 1'b0);

        // Bounce on row 0 / column 0: detection plus one confirming sample only.
        mask = 16'h1;
        wait_mode(M_CONFIRM, 0, 200, "bounce_detect");
        repeat (DIV) @(negedge clk);
        mask = 16'h0;
        repeat (40) @(negedge clk);
        check("bounce_no_key", {kif.key_valid, kif.key_held}, 2'b00);

        // '7' without ack, then '#' -> overwrite plus overrun.
        press(16'h1 << 8, 100, 60);
        press(16'h1 << 14, 100, 60);
        check("overrun_code", {kif.key_code, kif.key_valid, kif.overrun}, {4'hF, 1'b1, 1'b1});
        do_ack();
        check("overrun_sticky", {kif.key_valid, kif.overrun}, 2'b01);

        // Rows 0 and 2 together on column 3: lowest row wins.
        press((16'h1 << 3) | (16'h1 << 11), 100, 60);
        check("multi_row_code", {kif.key_code, kif.key_valid}, {4'hA, 1'b1});
        do_ack();

        // Scan disabled in the middle of press debounce.
        mask = 16'h1 << 6;
        wait_mode(M_CONFIRM, 0, 200, "en_detect");
        en = 1'b0;
        repeat (25) @(negedge clk);
        check("en_low_col", col, 4'hF);
        repeat (25) @(negedge clk);
        en = 1'b1;
        repeat (100) @(negedge clk);
        mask = 16'h0;
        repeat (60) @(negedge clk);
        check("en_resume_code", {kif.key_code, kif.key_valid}, {4'h6, 1'b1});
        do_ack();

        // Reset while a key is pressed and pending.
        mask = 16'h1 << 1;
        wait_mode(M_HELD, 1, 300, "rst_press");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_press", {col, kif.key_valid, kif.key_code, kif.key_held, kif.overrun}, {4'hE, 1'b0, 4'h0, 1'b0, 1'b0});
        @(negedge clk);
        mask = 16'h0;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);

        // Randomized presses, bounces, enables and acknowledges.
        for (int it = 0; it < 40; it++) begin
            logic [15:0] mk;
            mk = 16'h1 << $urandom_range(0, 15);
            if ($urandom_range(0, 2) == 0) mk = mk | (16'h1 << $urandom_range(0, 15));
            ack_rand = ($urandom_range(0, 1) == 1);
            mask = mk;
            repeat ($urandom_range(6, 120)) @(negedge clk);
            if ($urandom_range(0, 4) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 30)) @(negedge clk);
                en = 1'b1;
            end
            mask = 16'h0;
            repeat ($urandom_range(4, 80)) @(negedge clk);
        end
        ack_rand = 0;
        repeat (200) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
